conv_mac_core: RTL

Parametrised, pipelined multiply-accumulate core for the convolution datapath. Each accepted beat is one kernel window for one input channel. The core multiplies the window element-wise with the kernel weights, reduces the products through a registered adder tree, and accumulates across `pCHANNELS` beats. It then rounds, shifts and saturates the sum to `pDATA_W` and presents one output pixel under a valid/ready handshake. It sits between the window generator and the output feature-map writer, and is the successor to the fixed-kernel multiplier core.

---
 rtl/conv_mac_core.sv | 130 +++++++++++++
 1 files changed

// File: rtl/conv_mac_core.sv
// conv_mac_core: pipelined window MAC, channel accumulation, round/shift/saturate output.
// Optional macro CONV_MAC_BIAS_EN adds an ibias port that seeds each group's accumulation.
module conv_mac_core #(
  parameter int pDATA_W   = 8,
  parameter int pKERNEL_X = 3,
  parameter int pKERNEL_Y = 3,
  parameter int pCHANNELS = 4,
  parameter int pSHIFT    = 0
) (
  input  logic                                                 iclk,
  input  logic                                                 irst,
  input  logic [pKERNEL_Y-1:0][pKERNEL_X-1:0][pDATA_W-1:0]     idata,
  input  logic [pKERNEL_Y-1:0][pKERNEL_X-1:0][pDATA_W-1:0]     idata_kernel,
`ifdef CONV_MAC_BIAS_EN
  input  logic signed [2*pDATA_W-1:0]                          ibias,
`endif
  input  logic                                                 ivalid,
  output logic                                                 iready,
  output logic signed [pDATA_W-1:0]                            odata,
  output logic                                                 ovalid,
  input  logic                                                 oready,
  output logic                                                 osat
);
  localparam int K = pKERNEL_X * pKERNEL_Y;
  localparam int T = $clog2(K);
  localparam int PW = 2 * pDATA_W;
  localparam int SW = PW + T;
  localparam int ACC_W = PW + T + $clog2(pCHANNELS) + 1;
  localparam int CW = pCHANNELS > 1 ? $clog2(pCHANNELS) : 1;
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((64'd1 << pSHIFT) >> 1);
  localparam logic signed [ACC_W:0] HI = (ACC_W+1)'((64'd1 << (pDATA_W-1)) - 64'd1);
  localparam logic signed [ACC_W:0] LO = ~HI;

  logic adv, take, fst_in, lst_in;
  logic [CW-1:0] ch_cnt_q, ch_cnt_d;
  logic [pKERNEL_Y-1:0][pKERNEL_X-1:0][pDATA_W-1:0] din_q, din_d, win_q, win_d;
  logic signed [SW-1:0] tr_q [T+1][2*K];
  logic signed [SW-1:0] tr_d [T+1][2*K];
  logic [T+1:0] vld_q, vld_d, fst_q, fst_d, lst_q, lst_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, tsum, bias_ext;
  logic cv_q, cv_d, cl_q, cl_d;
  logic signed [ACC_W:0] rsum, rsh;
  logic signed [pDATA_W-1:0] odata_q, odata_d;
  logic ovalid_q, ovalid_d, osat_q, osat_d;
`ifdef CONV_MAC_BIAS_EN
  logic signed [PW-1:0] bias_q [T+2];
  logic signed [PW-1:0] bias_d [T+2];
`endif

  always_comb begin
    adv = !ovalid_q || oready;
    take = ivalid && adv;
    fst_in = ch_cnt_q == '0;
    lst_in = ch_cnt_q == CW'(pCHANNELS - 1);
    ch_cnt_d = take ? (lst_in ? '0 : ch_cnt_q + CW'(1)) : ch_cnt_q;
    din_d = adv ? idata : din_q;
    win_d = adv ? idata_kernel : win_q;
    vld_d = adv ? {vld_q[T:0], take} : vld_q;
    fst_d = adv ? {fst_q[T:0], fst_in} : fst_q;
    lst_d = adv ? {lst_q[T:0], lst_in} : lst_q;
    // slots past each level's operand count stay zero, so an odd leftover passes through as x+0
    tr_d = tr_q;
    for (int i = 0; i < K; i++)
      if (adv) tr_d[0][i] = SW'($signed(din_q[i/pKERNEL_X][i%pKERNEL_X])) * SW'($signed(win_q[i/pKERNEL_X][i%pKERNEL_X]));
    for (int l = 1; l <= T; l++)
      for (int i = 0; i < K; i++)
        if (adv) tr_d[l][i] = tr_q[l-1][2*i] + tr_q[l-1][2*i+1];
`ifdef CONV_MAC_BIAS_EN
    bias_d = bias_q;
    if (adv) bias_d[0] = ibias;
    for (int s = 1; s <= T + 1; s++)
      if (adv) bias_d[s] = bias_q[s-1];
    bias_ext = ACC_W'(bias_q[T+1]);
`else
    bias_ext = '0;
`endif
    tsum = ACC_W'(tr_q[T][0]);
    acc_d = (adv && vld_q[T+1]) ? (fst_q[T+1] ? tsum + bias_ext : acc_q + tsum) : acc_q;
    cv_d = adv ? vld_q[T+1] : cv_q;
    cl_d = adv ? lst_q[T+1] : cl_q;
    rsum = {acc_q[ACC_W-1], acc_q} + RND;
    rsh = rsum >>> pSHIFT;
    ovalid_d = adv ? (cv_q && cl_q) : ovalid_q;
    odata_d = (adv && cv_q && cl_q) ? (rsh > HI ? HI[pDATA_W-1:0] : rsh < LO ? LO[pDATA_W-1:0] : rsh[pDATA_W-1:0]) : odata_q;
    osat_d = (adv && cv_q && cl_q) ? (rsh > HI || rsh < LO) : osat_q;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      ch_cnt_q <= '0;
      din_q <= '0;
      win_q <= '0;
      tr_q <= '{default: '0};
      vld_q <= '0;
      fst_q <= '0;
      lst_q <= '0;
      acc_q <= '0;
      cv_q <= 1'b0;
      cl_q <= 1'b0;
      odata_q <= '0;
      ovalid_q <= 1'b0;
      osat_q <= 1'b0;
`ifdef CONV_MAC_BIAS_EN
      bias_q <= '{default: '0};
`endif
    end else begin
      ch_cnt_q <= ch_cnt_d;
      din_q <= din_d;
      win_q <= win_d;
      tr_q <= tr_d;
      vld_q <= vld_d;
      fst_q <= fst_d;
      lst_q <= lst_d;
      acc_q <= acc_d;
      cv_q <= cv_d;
      cl_q <= cl_d;
      odata_q <= odata_d;
      ovalid_q <= ovalid_d;
      osat_q <= osat_d;
`ifdef CONV_MAC_BIAS_EN
      bias_q <= bias_d;
`endif
    end
  end

  assign iready = adv;
  assign odata = odata_q;
  assign ovalid = ovalid_q;
  assign osat = osat_q;
endmodule
